// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite command master.
// Provides the FSM state encoding, AXI response / completion status codes,
// default widths and the AXI-response to completion-status mapping.
package axil_pkg;

    localparam int AXIL_ADDR_W  = 8;
    localparam int AXIL_DATA_W  = 32;
    localparam int AXIL_TIMEOUT = 16;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } axil_state_e;

    // OKAY/EXOKAY collapse to OKAY; SLVERR/DECERR collapse to SLVERR.
    function automatic logic [1:0] map_resp(input logic [1:0] resp);
        return (resp >= 2'b10) ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_timeout_ctr.sv
// Watchdog counter for one AXI phase.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : force count to zero (takes priority over enable)
//   enable    : count this cycle
//   expired   : high while enabled and the count has reached TIMEOUT-1
module axil_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // The owner leaves the phase on expiry, so count never passes TIMEOUT-1.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding command master driving an AXI-Lite slave.
// A command (read/write, word address, write data) is accepted on the
// cmd_* stream, issued on AW/W/B or AR/R, and its completion is returned on
// the rsp_* stream. A watchdog aborts any AXI phase that stalls for TIMEOUT
// cycles and reports status 3.
// Ports:
//   AXI_ACLK, AXI_ARESET         : clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command stream
//   rsp_valid/ready/write/rdata/status : completion stream
//   AXI_AW*, AXI_W*, AXI_B*       : AXI-Lite write channels
//   AXI_AR*, AXI_R*               : AXI-Lite read channels
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int ADDR_W  = AXIL_ADDR_W,
    parameter int DATA_W  = AXIL_DATA_W,
    parameter int TIMEOUT = AXIL_TIMEOUT
) (
    input  logic                AXI_ACLK,
    input  logic                AXI_ARESET,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_status,

    output logic [ADDR_W-1:0]   AXI_AWADDR,
    output logic                AXI_AWVALID,
    input  logic                AXI_AWREADY,
    output logic [DATA_W-1:0]   AXI_WDATA,
    output logic [DATA_W/8-1:0] AXI_WSTRB,
    output logic                AXI_WVALID,
    input  logic                AXI_WREADY,
    input  logic [1:0]          AXI_BRESP,
    input  logic                AXI_BVALID,
    output logic                AXI_BREADY,
    output logic [ADDR_W-1:0]   AXI_ARADDR,
    output logic                AXI_ARVALID,
    input  logic                AXI_ARREADY,
    input  logic [DATA_W-1:0]   AXI_RDATA,
    input  logic [1:0]          AXI_RRESP,
    input  logic                AXI_RVALID,
    output logic                AXI_RREADY
);

    axil_state_e         state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                write_q;

    logic aw_ok;
    logic w_ok;
    logic busy;
    logic done;
    logic expired;

    assign AXI_AWADDR = addr_q;
    assign AXI_ARADDR = addr_q;
    assign AXI_WDATA  = wdata_q;
    assign AXI_WSTRB  = '1;

    // done: the handshake that ends the current state happens at this edge.
    always_comb begin
        aw_ok = !AXI_AWVALID || AXI_AWREADY;
        w_ok  = !AXI_WVALID  || AXI_WREADY;
        busy  = (state == WR_REQ) || (state == WR_RESP) ||
                (state == RD_REQ) || (state == RD_RESP);
        done  = 1'b0;
        case (state)
            IDLE:    done = cmd_valid && cmd_ready;
            WR_REQ:  done = aw_ok && w_ok;
            WR_RESP: done = AXI_BVALID;
            RD_REQ:  done = AXI_ARREADY;
            RD_RESP: done = AXI_RVALID;
            RSP:     done = rsp_ready;
            default: done = 1'b0;
        endcase
    end

    // Any state change (normal or abort) restarts the watchdog.
    axil_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (AXI_ACLK),
        .rst     (AXI_ARESET),
        .clear   (done || expired),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_status  <= RESP_OKAY;
            AXI_AWVALID <= 1'b0;
            AXI_WVALID  <= 1'b0;
            AXI_BREADY  <= 1'b0;
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        write_q   <= cmd_write;
                        if (cmd_write) begin
                            AXI_AWVALID <= 1'b1;
                            AXI_WVALID  <= 1'b1;
                            state       <= WR_REQ;
                        end else begin
                            AXI_ARVALID <= 1'b1;
                            state       <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    // AW and W retire independently; leave once both are done.
                    if (AXI_AWVALID && AXI_AWREADY) AXI_AWVALID <= 1'b0;
                    if (AXI_WVALID && AXI_WREADY)   AXI_WVALID  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        AXI_BREADY <= 1'b1;
                        state      <= WR_RESP;
                    end else if (expired) begin
                        AXI_AWVALID <= 1'b0;
                        AXI_WVALID  <= 1'b0;
                        rsp_write   <= write_q;
                        rsp_rdata   <= '0;
                        rsp_status  <= STAT_TIMEOUT;
                        rsp_valid   <= 1'b1;
                        state       <= RSP;
                    end
                end

                WR_RESP: begin
                    // BREADY stays high so a one-cycle BVALID pulse is caught.
                    if (AXI_BVALID) begin
                        AXI_BREADY <= 1'b0;
                        rsp_write  <= 1'b1;
                        rsp_rdata  <= '0;
                        rsp_status <= map_resp(AXI_BRESP);
                        rsp_valid  <= 1'b1;
                        state      <= RSP;
                    end else if (expired) begin
                        AXI_BREADY <= 1'b0;
                        rsp_write  <= write_q;
                        rsp_rdata  <= '0;
                        rsp_status <= STAT_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        state      <= RSP;
                    end
                end

                RD_REQ: begin
                    if (AXI_ARREADY) begin
                        AXI_ARVALID <= 1'b0;
                        AXI_RREADY  <= 1'b1;
                        state       <= RD_RESP;
                    end else if (expired) begin
                        AXI_ARVALID <= 1'b0;
                        rsp_write   <= write_q;
                        rsp_rdata   <= '0;
                        rsp_status  <= STAT_TIMEOUT;
                        rsp_valid   <= 1'b1;
                        state       <= RSP;
                    end
                end

                RD_RESP: begin
                    if (AXI_RVALID) begin
                        AXI_RREADY <= 1'b0;
                        rsp_write  <= 1'b0;
                        rsp_rdata  <= AXI_RDATA;
                        rsp_status <= map_resp(AXI_RRESP);
                        rsp_valid  <= 1'b1;
                        state      <= RSP;
                    end else if (expired) begin
                        AXI_RREADY <= 1'b0;
                        rsp_write  <= write_q;
                        rsp_rdata  <= '0;
                        rsp_status <= STAT_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        state      <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
